// File: rtl/cic_demix_decim.sv
// Receive-side LO demixer followed by an N-stage CIC decimator (decimate by R).
// Emits one OUT_W-bit floor-truncated sample per R accepted inputs.
module cic_demix_decim #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 20,
  parameter int unsigned R     = 50,
  parameter int unsigned N     = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [IN_W-1:0]        d_in,
  input  logic [1:0]             lo,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       d_out,
  output logic [$clog2(R)-1:0]   phase
);

  localparam int unsigned CW = $clog2(R);
  localparam int unsigned MW = IN_W + 1;
  localparam int unsigned W  = MW + N * CW;
  localparam int unsigned SH = W - OUT_W;

  logic signed [MW-1:0] din_ext_c;
  logic signed [MW-1:0] mix_c;
  logic signed [W-1:0]  mix_w_c;
  logic signed [W-1:0]  integ [N];
  logic signed [W-1:0]  dly [N];
  logic signed [W-1:0]  stage_in_c [N];
  logic signed [W-1:0]  comb_out_c;
  logic                 dump;

  // One extra bit so that negating the most negative input cannot overflow.
  assign din_ext_c = {d_in[IN_W-1], d_in};

  always_comb begin : demix
    mix_c = '0;
    case (lo)
      2'b01:   mix_c = din_ext_c;
      2'b10:   mix_c = -din_ext_c;
      default: mix_c = '0;
    endcase
  end

  assign mix_w_c = {{(W - MW){mix_c[MW-1]}}, mix_c};

  // Integrator chain: modular arithmetic, each stage adds the previous stage's old value.
  always_ff @(posedge clock or posedge reset) begin : integrators
    if (reset) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + mix_w_c;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Comb chain evaluated combinationally from the last integrator at the dump edge.
  always_comb begin : comb_chain
    logic signed [W-1:0] acc_c;
    acc_c = integ[N-1];
    for (int k = 0; k < N; k++) begin
      stage_in_c[k] = acc_c;
      acc_c = acc_c - dly[k];
    end
    comb_out_c = acc_c;
  end

  always_ff @(posedge clock or posedge reset) begin : comb_delays
    if (reset) begin
      for (int k = 0; k < N; k++) dly[k] <= '0;
    end else if (dump) begin
      for (int k = 0; k < N; k++) dly[k] <= stage_in_c[k];
    end
  end

  // Phase counts accepted samples only; the wrap edge raises dump for one cycle.
  always_ff @(posedge clock or posedge reset) begin : control
    if (reset) begin
      phase     <= '0;
      dump      <= 1'b0;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else begin
      out_valid <= dump;
      dump      <= 1'b0;
      if (dump) d_out <= OUT_W'(comb_out_c >>> SH);
      if (in_valid) begin
        if (phase == CW'(R - 1)) begin
          phase <= '0;
          dump  <= 1'b1;
        end else begin
          phase <= phase + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/cic_demix_decim.md
Name: cic_demix_decim

Overview:
- Receive-side counterpart of the interpolator/mixer path.
- Accepts full-rate signed samples and demixes them with the same 2-bit LO code the mixer uses.
- Decimates by R through an N-stage CIC filter and emits one OUT_W-bit sample per R accepted inputs, at the ds_clock sample rate.
- Sits between the fast-clock loopback/capture point and the low-rate sample checker.

Parameters:
- IN_W, 20, input sample width (signed two's complement)
- OUT_W, 20, output sample width (signed)
- R, 50, decimation ratio (>=2)
- N, 3, number of integrator/comb stages (1..5)
- Derived: MW = IN_W+1 (mixed width); W = MW + N*clog2(R) (internal width; 39 at defaults); SH = W-OUT_W (19 at defaults)

Ports:
- clock  in  1  fast clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  d_in/lo accepted on the rising edge where high
- d_in  in  IN_W  signed input sample
- lo  in  2  LO code: 2'b01 = +d_in, 2'b10 = -d_in, 2'b00 = 0, 2'b11 = 0
- out_valid  out  1  one-cycle strobe, d_out newly valid
- d_out  out  OUT_W  signed decimated sample, held between strobes
- phase  out  clog2(R)  count of accepted samples in current decimation window (0..R-1)

Behaviour:
- Reset (async, high): integrators, comb delay registers, phase, dump flag, d_out and out_valid all go to 0. While reset is high, in_valid is ignored.
- Demix (combinational): m = sign-extend(d_in) to MW bits, then negated/zeroed per lo. -2^(IN_W-1) with lo=10 yields +2^(IN_W-1) without overflow.
- Integrators (N cascaded, W bits):
  - Update only on edges with in_valid=1: I1 += sext(m); Ik += I(k-1) (old values, registered chain).
  - Hold otherwise.
  - Modular wrap-around is intended and must not saturate.
- Phase counter:
  - Increments on each accepted sample.
  - On the edge accepting a sample while phase==R-1, it wraps to 0 and sets the dump flag (registered, one cycle).
  - Gaps in in_valid stretch the window; only accepted samples count.
- Comb stage:
  - On the edge where dump=1, the comb chain is computed combinationally from the current IN (last integrator) value: C1 = IN - D1; Ck = C(k-1) - Dk. Each Dk is loaded with its stage input.
  - d_out <= C_N[W-1:SH] (arithmetic truncation, i.e. floor) and out_valid <= 1.
  - out_valid deasserts on the next edge unless dump is set again (impossible for R>=2).
- Latency: the R-th sample is accepted at edge E0; out_valid is high for exactly the cycle following edge E1. d_out changes only at strobe edges.
- The in_valid=1 at the dump edge is still accepted into the integrators and counts as phase 1 of the next window.
- DC gain: R^N / 2^SH relative to the mixed input (0.2384 at defaults).
- Transient: outputs 1..N-1 after reset are partial; from output N onward a constant input gives a constant output.
- Reset asserted mid-window or during dump: everything clears immediately; no strobe is produced for the partial window.

Test Plan:
- Reset: hold reset for 5 cycles with in_valid=1, d_in=1000, lo=01 -> out_valid=0, d_out=0, phase=0 throughout. Deassert -> first out_valid exactly 1 cycle after the edge accepting the 50th sample.
- DC plus: d_in=1000, lo=01, in_valid=1 continuously -> out_valid every 50 cycles. d_out = floor(1000*125000/2^19) = 238 from the 3rd strobe onward.
- DC minus and zero: the same with lo=10 -> d_out=-239; with lo=00 or lo=11 -> d_out=0 at every strobe.
- Full scale: d_in=-524288, lo=10 -> steady d_out=+125000, with no sign flip despite internal integrator wrap over 20000+ cycles.
- Throttled input: in_valid high every other cycle, d_in=1000, lo=01 -> strobes every 100 cycles. Steady d_out=238, and phase holds during gaps.
- Mid-window reset: assert reset at phase=30 -> no strobe. After release, the next strobe occurs after 50 fresh accepted samples, and the transient sequence restarts identically to the post-reset case.
